// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-ported data memory that uses a
// busywait handshake. One request is granted at a time. Its address, data and
// operation are latched and driven to the memory. When the memory finishes,
// read data is returned and the winner's busywait is released for one cycle.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  // port 0: data access from the MEM stage
  input  logic                  p0_read,
  input  logic                  p0_write,
  input  logic [ADDR_WIDTH-1:0] p0_address,
  input  logic [DATA_WIDTH-1:0] p0_writedata,
  output logic [DATA_WIDTH-1:0] p0_readdata,
  output logic                  p0_busywait,
  // port 1: instruction fetch or a second master
  input  logic                  p1_read,
  input  logic                  p1_write,
  input  logic [ADDR_WIDTH-1:0] p1_address,
  input  logic [DATA_WIDTH-1:0] p1_writedata,
  output logic [DATA_WIDTH-1:0] p1_readdata,
  output logic                  p1_busywait,
  // shared memory side
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic [DATA_WIDTH-1:0] mem_readdata,
  input  logic                  mem_busywait
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  grant_reg, grant_next;
  logic                  last_grant_reg, last_grant_next;
  logic                  busy_seen_reg, busy_seen_next;
  logic                  mem_read_reg, mem_read_next;
  logic                  mem_write_reg, mem_write_next;
  logic [ADDR_WIDTH-1:0] mem_address_reg, mem_address_next;
  logic [DATA_WIDTH-1:0] mem_writedata_reg, mem_writedata_next;

  // Requests gathered into indexable form so both ports share one code path.
  logic [1:0]                  port_write;
  logic [1:0]                  port_req;
  logic [ADDR_WIDTH-1:0]       port_addr [2];
  logic [DATA_WIDTH-1:0]       port_wdata [2];
  logic [1:0]                  busywait_all;
  logic [1:0][DATA_WIDTH-1:0]  readdata_all;

  logic winner;
  logic access_min_elapsed;
  logic access_complete;
  logic read_capture;

  assign port_write    = {p1_write, p0_write};
  assign port_req      = {p1_read | p1_write, p0_read | p0_write};
  assign port_addr[0]  = p0_address;
  assign port_addr[1]  = p1_address;
  assign port_wdata[0] = p0_writedata;
  assign port_wdata[1] = p1_writedata;

  // Any ACCESS edge is at least one full cycle after the grant edge, so the
  // minimum-dwell half of the completion condition holds whenever we are there.
  assign access_min_elapsed = (state_reg == ACCESS);
  assign access_complete    = (state_reg == ACCESS) && !mem_busywait &&
                              (busy_seen_reg || access_min_elapsed);
  // Read data is captured only on the completion edge of a read.
  assign read_capture       = access_complete && mem_read_reg;

  // Per-port busywait and registered read data.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      localparam logic PORT_ID = (gi == 1);
      logic [DATA_WIDTH-1:0] readdata_reg;

      assign busywait_all[gi] = port_req[gi] &
                                ~((state_reg == DONE) && (grant_reg == PORT_ID));
      assign readdata_all[gi] = readdata_reg;

      // Only the granted port's read data register ever loads.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          readdata_reg <= '0;
        end else if (read_capture && (grant_reg == PORT_ID)) begin
          readdata_reg <= mem_readdata;
        end
      end
    end
  endgenerate

  assign p0_busywait   = busywait_all[0];
  assign p1_busywait   = busywait_all[1];
  assign p0_readdata   = readdata_all[0];
  assign p1_readdata   = readdata_all[1];
  assign mem_read      = mem_read_reg;
  assign mem_write     = mem_write_reg;
  assign mem_address   = mem_address_reg;
  assign mem_writedata = mem_writedata_reg;

  // Pick the port to grant from the live requests in IDLE.
  always_comb begin
    winner = 1'b0;
    if (port_req == 2'b11) begin
      winner = ROUND_ROBIN ? ~last_grant_reg : 1'b0;
    end else begin
      winner = port_req[1];
    end
  end

  // State register; reset aborts any access in flight and drops the strobes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      grant_reg         <= 1'b0;
      last_grant_reg    <= 1'b1;
      busy_seen_reg     <= 1'b0;
      mem_read_reg      <= 1'b0;
      mem_write_reg     <= 1'b0;
      mem_address_reg   <= '0;
      mem_writedata_reg <= '0;
    end else begin
      state_reg         <= state_next;
      grant_reg         <= grant_next;
      last_grant_reg    <= last_grant_next;
      busy_seen_reg     <= busy_seen_next;
      mem_read_reg      <= mem_read_next;
      mem_write_reg     <= mem_write_next;
      mem_address_reg   <= mem_address_next;
      mem_writedata_reg <= mem_writedata_next;
    end
  end

  // Next-state logic: grant and latch in IDLE, hold in ACCESS, release in DONE.
  always_comb begin
    state_next         = state_reg;
    grant_next         = grant_reg;
    last_grant_next    = last_grant_reg;
    busy_seen_next     = busy_seen_reg;
    mem_read_next      = mem_read_reg;
    mem_write_next     = mem_write_reg;
    mem_address_next   = mem_address_reg;
    mem_writedata_next = mem_writedata_reg;

    case (state_reg)
      IDLE: begin
        if (|port_req) begin
          // Read+write together counts as a write.
          grant_next         = winner;
          mem_address_next   = port_addr[winner];
          mem_writedata_next = port_wdata[winner];
          mem_write_next     = port_write[winner];
          mem_read_next      = ~port_write[winner];
          busy_seen_next     = 1'b0;
          state_next         = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_busywait) begin
          busy_seen_next = 1'b1;
        end
        if (access_complete) begin
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          state_next     = DONE;
        end
      end
      DONE: begin
        last_grant_next = grant_reg;
        state_next      = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
